// File: rtl/key_ctrl_pkg.sv
// Shared constants for the push-button controller: Avalon register map
// and the width of the debounce-length field.
package key_ctrl_pkg;

    localparam logic [1:0] KEY_ADDR_DATA  = 2'd0;
    localparam logic [1:0] KEY_ADDR_DBLEN = 2'd1;
    localparam logic [1:0] KEY_ADDR_MASK  = 2'd2;
    localparam logic [1:0] KEY_ADDR_EDGE  = 2'd3;

    localparam int DBLEN_W = 8;

endpackage

// File: rtl/key_debounce_chan.sv
// One debounce channel: tracks a qualified key state and pulses `press`
// for one cycle when that state goes from released to pressed.
module key_debounce_chan
    import key_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               raw,
    input  logic               tick,
    input  logic [DBLEN_W-1:0] dblen,
    input  logic               cnt_clr,
    output logic               stable,
    output logic               press
);

    logic [DBLEN_W-1:0] cnt;
    logic [DBLEN_W-1:0] cnt_nxt;
    logic [DBLEN_W-1:0] cnt_inc;
    logic               stable_nxt;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        stable_nxt = stable;
        cnt_nxt    = cnt;
        cnt_inc    = cnt + DBLEN_W'(1);
        if (dblen == '0) begin
            stable_nxt = raw;
            cnt_nxt    = '0;
        end else if (cnt_clr || (raw == stable)) begin
            cnt_nxt = '0;
        end else if (tick) begin
            if (cnt_inc == dblen) begin
                stable_nxt = raw;
                cnt_nxt    = '0;
            end else begin
                cnt_nxt = cnt_inc;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            stable <= stable_nxt;
            cnt    <= cnt_nxt;
            press  <= stable_nxt & ~stable;
        end
    end

endmodule

// File: rtl/key_debounce_ctrl.sv
// Avalon-MM push-button controller: synchronises and debounces active-low
// keys, latches press edges into a W1C register and raises a masked irq.
module key_debounce_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int N_KEYS   = 4,
    parameter int TICK_DIV = 50000,
    parameter int DB_TICKS = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n,
    input  logic [1:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int                PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [N_KEYS-1:0]  sync0;
    logic [N_KEYS-1:0]  sync1;
    logic [N_KEYS-1:0]  raw;
    logic [PRE_W-1:0]   pre;
    logic               tick;
    logic [DBLEN_W-1:0] dblen;
    logic [N_KEYS-1:0]  mask;
    logic [N_KEYS-1:0]  mask_nxt;
    logic [N_KEYS-1:0]  edge_cap;
    logic [N_KEYS-1:0]  edge_nxt;
    logic [N_KEYS-1:0]  clr;
    logic [N_KEYS-1:0]  stable_vec;
    logic [N_KEYS-1:0]  press_vec;
    logic [31:0]        rd_mux;
    logic               wr_dblen;
    logic               wr_mask;
    logic               wr_edge;
    logic               unused_wdata;

    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0 <= '0;
            sync1 <= '0;
        end else begin
            sync0 <= key_n;
            sync1 <= sync0;
        end
    end

    assign raw = ~sync1;

    // Free-running; the tick lands in the cycle the count has wrapped to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (pre == PRE_LAST);
            pre  <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
        end
    end

    assign wr_dblen = write && (address == KEY_ADDR_DBLEN);
    assign wr_mask  = write && (address == KEY_ADDR_MASK);
    assign wr_edge  = write && (address == KEY_ADDR_EDGE);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_debounce_chan u_chan (
            .clk     (clk),
            .reset   (reset),
            .raw     (raw[i]),
            .tick    (tick),
            .dblen   (dblen),
            .cnt_clr (wr_dblen),
            .stable  (stable_vec[i]),
            .press   (press_vec[i])
        );
    end

    // A press arriving with a clear of the same bit keeps the bit set.
    assign clr      = wr_edge ? writedata[N_KEYS-1:0] : '0;
    assign edge_nxt = (edge_cap & ~clr) | press_vec;
    assign mask_nxt = wr_mask ? writedata[N_KEYS-1:0] : mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            dblen    <= DBLEN_W'(DB_TICKS);
            mask     <= '0;
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_dblen) begin
                dblen <= writedata[DBLEN_W-1:0];
            end
            mask     <= mask_nxt;
            edge_cap <= edge_nxt;
            irq      <= |(edge_nxt & mask_nxt);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            KEY_ADDR_DATA:  rd_mux[N_KEYS-1:0]  = stable_vec;
            KEY_ADDR_DBLEN: rd_mux[DBLEN_W-1:0] = dblen;
            KEY_ADDR_MASK:  rd_mux[N_KEYS-1:0]  = mask;
            KEY_ADDR_EDGE:  rd_mux[N_KEYS-1:0]  = edge_cap;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: doc/key_debounce_ctrl.md
# key_debounce_ctrl

Controller for the board push-buttons on the Avalon-MM bus. Synchronises and debounces the raw active-low key inputs with a shared millisecond prescaler and per-key stability counters, and latches press edges into a sticky capture register. Raises a maskable interrupt. Sits between the key pins and the HPS/Nios interconnect, and replaces direct polling of the raw key port.

## Interface
Parameters:
- `N_KEYS`, 4, number of keys; 1..32.
- `TICK_DIV`, 50000, clk cycles per debounce tick (1 ms at 50 MHz); ≥2.
- `DB_TICKS`, 20, reset value of the debounce-length register (ticks).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `key_n`  in  N_KEYS  raw key pins, asynchronous, active-low (0 = pressed).
- `address`  in  2  Avalon word address.
- `read`  in  1  Avalon read strobe.
- `write`  in  1  Avalon write strobe.
- `writedata`  in  32  Avalon write data.
- `readdata`  out  32  registered read data; reset 0.
- `irq`  out  1  level interrupt; reset 0.

## Operation
- Register map:
  - 0 DATA (RO): debounced state, 1 = pressed.
  - 1 DBLEN (RW): bits [7:0] give the debounce length in ticks.
  - 2 IRQMASK (RW): bits [N_KEYS-1:0].
  - 3 EDGE (RW1C): sticky press capture.
- Unused bits read 0. Writes to DATA are ignored.
- Input path: two-flop synchroniser per key, then inverted to `raw[i]` (1 = pressed).
- Prescaler: counts 0..TICK_DIV-1 and emits a one-cycle `tick` when it wraps to 0. Free-running; not affected by register writes.
- Per-key channel, with state `stable` and an 8-bit counter `cnt`:
  - `raw == stable`: `cnt` ← 0 on every cycle.
  - `raw != stable` and `tick`: `cnt` ← `cnt + 1`. When `cnt + 1 == DBLEN`, `stable` ← `raw` and `cnt` ← 0.
  - `DBLEN == 0`: bypass. `stable` ← `raw` every cycle.
  - Any write to DBLEN clears every `cnt` in the same cycle.
- Press event: one-cycle pulse when `stable` goes 0→1. Releases never set EDGE.
- EDGE: `edge` ← `(edge & ~clr) | press`, where `clr` = `writedata` bits when `write && address==3`. If a set and a clear hit the same bit in the same cycle, the set wins.
- `irq` = OR of (`edge & mask`). Driven directly from flops; no combinational path from bus inputs.
- Reads: `readdata` ← selected register on every cycle where `read` is high. Otherwise it holds its value.
- Reset: synchroniser, `stable`, `cnt`, prescaler, EDGE, IRQMASK and `readdata` go to 0. DBLEN goes to `DB_TICKS`. A reset during a bounce interval discards it; no press is reported unless the key is re-qualified after reset.

## Timing
- Read latency is 1 cycle: `readdata` is valid the cycle after `read`. No waitrequest. Writes take effect at the clock edge where `write` is sampled.
- A register read in the same cycle as a write to that register returns the old value.
- Press-to-DATA latency:
  - Minimum: 2 (sync) + (DBLEN−1)·TICK_DIV + 1 cycles.
  - Maximum: 2 + DBLEN·TICK_DIV cycles.
- EDGE sets 1 cycle after DATA rises. `irq` rises in that same cycle if the mask bit is set.
- A bounce shorter than one tick, or any glitch that returns to `stable` before reaching DBLEN ticks, never changes DATA.
- Setting a mask bit while the matching EDGE bit is already set asserts `irq` the next cycle. Clearing either bit deasserts it the next cycle.

## Structure
- Package `key_ctrl_pkg` holds:
  - register address constants `KEY_ADDR_DATA`, `KEY_ADDR_DBLEN`, `KEY_ADDR_MASK`, `KEY_ADDR_EDGE`;
  - `DBLEN_W = 8`.
- Sub-module `key_debounce_chan`: one instance per key, generated N_KEYS times.
  - Inputs: `clk`, `reset`, `raw`, `tick`, `dblen`, `cnt_clr`.
  - Outputs: `stable`, `press`.
- The top level holds the synchroniser, prescaler, bus registers and `irq`.

## Test plan
All scenarios use TICK_DIV=4, DB_TICKS=3, N_KEYS=4.
- Clean press: `key_n[0]` 1→0 and held → DATA=0x1 within 2+12 cycles, EDGE=0x1, `irq` stays 0 (mask 0). Write MASK=0x1 → `irq`=1 on the next cycle.
- Bounce: toggle `key_n[1]` every 5 cycles for 40 cycles, then release → DATA bit 1 never sets, EDGE=0.
- W1C race: EDGE=0x1 with a new `key_n[2]` press event arriving in the same cycle as a write of 0x4 to EDGE → EDGE=0x5 afterwards. A later write of 0x5 → EDGE=0, `irq`=0.
- DBLEN bypass: write DBLEN=0, pulse `key_n[3]` low for 1 cycle → DATA bit 3 pulses for 1 cycle, EDGE bit 3 sets. Read DBLEN returns 0x0.
- Reset mid-qualification: `key_n[0]` held low, assert `reset` after 2 ticks → all outputs 0, DBLEN reads 3. Release `reset` with the key still held → press reported once after full qualification.
- Read latency: issue reads of DATA, DBLEN, MASK and EDGE back-to-back → each value appears exactly 1 cycle after its `read`, upper bits 0.
